// File: rtl/boot_loader_pkg.sv
// Shared constants and state types for the UART boot loader.
package boot_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] GO_BYTE   = 8'h5A;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;

   // Packet parser states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_CSUM,
      ST_WRITE
   } boot_state_t;

   // Receive byte framer states
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Saturating 16-bit increment for the accepted-write counter
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, start-bit glitch rejection,
// mid-bit sampling, one-cycle o_valid / o_frame_err pulses.
module uart_rx_byte
   import boot_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rxd,
   output logic [7:0] o_byte,
   output logic       o_valid,
   output logic       o_frame_err
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [2:0]       sync_q;
   logic             rxd_s;
   logic             rxd_prev;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_d, ferr_d;

   // sync_q[1] is the synchronised line, sync_q[2] its previous value
   assign rxd_s    = sync_q[1];
   assign rxd_prev = sync_q[2];
   assign o_byte   = shift_q;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q      <= '1;
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         sync_q      <= {sync_q[1:0], i_rxd};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         o_valid     <= valid_d;
         o_frame_err <= ferr_d;
      end
   end

   // Next-state: bit timing and sampling
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (rxd_prev && !rxd_s) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rxd_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rxd_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               valid_d = rxd_s;
               ferr_d  = !rxd_s;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses A5/addr/data/csum write packets into the boot
// memory write port; 5A sets the sticky o_boot_done.
// Optional feature macro: UART_BOOT_ECHO_EN (ACK/NAK responses on o_uart_txd).
module uart_boot_loader
   import boot_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned TIMEOUT_CLKS = 100000
)
(
   input  logic              clk_uart,
   input  logic              clk_uart_rst_n,
   input  logic              i_uart_rxd,
   input  logic              i_mem_busy,
   output logic              o_mem_wr,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic              o_boot_done,
   output logic              o_pkt_err,
   output logic [15:0]       o_pkt_count,
   output logic              o_uart_txd
);

   localparam int unsigned      TMO_W        = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [31:0]      ADDR_HI_MASK = ~((32'd1 << (ADDR_W + 2)) - 32'd1);

   logic [7:0]        rx_byte;
   logic              rx_valid, rx_ferr;

   boot_state_t       state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [7:0]        csum_q, csum_d;
   logic              done_q, done_d;
   logic [15:0]       count_q, count_d;
   logic              err_q, err_d;
   logic              wr;
   logic              load_out;
   logic              pkt_bad;
   logic [TMO_W-1:0]  tmo_q;
   logic              tmo_expire;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk         (clk_uart),
      .rst_n       (clk_uart_rst_n),
      .i_rxd       (i_uart_rxd),
      .o_byte      (rx_byte),
      .o_valid     (rx_valid),
      .o_frame_err (rx_ferr)
   );

   assign tmo_expire  = (tmo_q == TMO_LAST);
   assign pkt_bad     = (rx_byte != csum_q) || (addr_q[1:0] != 2'b00) ||
                        ((addr_q & ADDR_HI_MASK) != '0);

   assign o_mem_wr    = wr;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_boot_done = done_q;
   assign o_pkt_err   = err_q;
   assign o_pkt_count = count_q;

   // Parser state and output holding registers
   always_ff @(posedge clk_uart) begin
      if (!clk_uart_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         csum_q      <= '0;
         done_q      <= 1'b0;
         count_q     <= '0;
         err_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         csum_q  <= csum_d;
         done_q  <= done_d;
         count_q <= count_d;
         err_q   <= err_d;
         if (load_out) begin
            mem_addr_q  <= addr_q[ADDR_W+1:2];
            mem_wdata_q <= data_q;
         end
      end
   end

   // Inter-byte timeout: idle in IDLE/WRITE, cleared by every received byte
   always_ff @(posedge clk_uart) begin
      if (!clk_uart_rst_n) begin
         tmo_q <= '0;
      end else if (rx_valid || rx_ferr || state_q == ST_IDLE ||
                   state_q == ST_WRITE || tmo_expire) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   // Next-state: packet parsing, discard decisions and write strobe
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      csum_d   = csum_q;
      done_d   = done_q;
      count_d  = count_q;
      err_d    = 1'b0;
      wr       = 1'b0;
      load_out = 1'b0;
      // A framing error aborts any packet in progress; a pending write is kept
      if (rx_ferr && !done_q && state_q != ST_WRITE) begin
         err_d   = 1'b1;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rx_valid && !done_q) begin
                  if (rx_byte == SYNC_BYTE) begin
                     state_d = ST_ADDR;
                     cnt_d   = '0;
                     csum_d  = '0;
                  end else if (rx_byte == GO_BYTE) begin
                     done_d = 1'b1;
                  end
               end
            end
            ST_ADDR: begin
               if (rx_valid) begin
                  addr_d = {addr_q[23:0], rx_byte};
                  csum_d = csum_q ^ rx_byte;
                  if (cnt_q == 2'd3) begin
                     state_d = ST_DATA;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end else if (tmo_expire) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_DATA: begin
               if (rx_valid) begin
                  data_d = {data_q[23:0], rx_byte};
                  csum_d = csum_q ^ rx_byte;
                  if (cnt_q == 2'd3) begin
                     state_d = ST_CSUM;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end else if (tmo_expire) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_CSUM: begin
               if (rx_valid) begin
                  if (pkt_bad) begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     load_out = 1'b1;
                     state_d  = ST_WRITE;
                  end
               end else if (tmo_expire) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_WRITE: begin
               if (!i_mem_busy) begin
                  wr      = 1'b1;
                  count_d = sat_inc16(count_q);
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef UART_BOOT_ECHO_EN
   localparam int unsigned        TX_CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TX_CNT_W-1:0] TX_BIT_LAST = TX_CNT_W'(CLKS_PER_BIT - 1);

   logic                resp_req;
   logic [7:0]          resp_byte;
   logic                tx_busy_q;
   logic [9:0]          tx_shift_q;
   logic [3:0]          tx_bits_q;
   logic [TX_CNT_W-1:0] tx_baud_q;
   logic                pend_q;
   logic [7:0]          pend_byte_q;
   logic                tx_bit_end;
   logic                tx_free;

   assign resp_req   = wr | (done_d & ~done_q) | err_d;
   assign resp_byte  = err_d ? NAK : ACK;
   assign tx_bit_end = tx_busy_q && (tx_baud_q == TX_BIT_LAST);
   // Serialiser can accept a new byte now, including the last cycle of a stop bit
   assign tx_free    = !tx_busy_q || (tx_bit_end && tx_bits_q == 4'd9);
   assign o_uart_txd = tx_busy_q ? tx_shift_q[0] : 1'b1;

   // Response serialiser with a one-deep queue; a third response is dropped
   always_ff @(posedge clk_uart) begin
      if (!clk_uart_rst_n) begin
         tx_busy_q   <= 1'b0;
         tx_shift_q  <= '1;
         tx_bits_q   <= '0;
         tx_baud_q   <= '0;
         pend_q      <= 1'b0;
         pend_byte_q <= '0;
      end else if (tx_free && (pend_q || resp_req)) begin
         tx_busy_q   <= 1'b1;
         tx_baud_q   <= '0;
         tx_bits_q   <= '0;
         tx_shift_q  <= {1'b1, (pend_q ? pend_byte_q : resp_byte), 1'b0};
         // queued byte goes out first; a same-cycle response takes its slot
         pend_q      <= pend_q && resp_req;
         pend_byte_q <= resp_byte;
      end else begin
         if (tx_free) begin
            tx_busy_q <= 1'b0;
         end else if (tx_bit_end) begin
            tx_baud_q  <= '0;
            tx_bits_q  <= tx_bits_q + 4'd1;
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
         end else if (tx_busy_q) begin
            tx_baud_q <= tx_baud_q + TX_CNT_W'(1);
         end
         if (resp_req && !pend_q) begin
            pend_q      <= 1'b1;
            pend_byte_q <= resp_byte;
         end
      end
   end
`else
   assign o_uart_txd = 1'b1;
`endif

endmodule
